hilo_writeback: RTL and testbench
=================================

Name: hilo_writeback

Overview:
- Downstream consumer of the 32-bit divider and multiplier.
- Accepts the 64-bit raw result {Q,R} or {P_hi,P_lo} through a valid/ready handshake and applies signed fix-up to the unsigned-magnitude result.
- Commits the fixed-up result to the architectural HI/LO registers and serves mfhi/mflo/mthi/mtlo with stall interlock.
- Sits between the mul/div datapath and the register-file writeback mux.

Parameters:
- W, 32, architectural word width; result bus is 2*W.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- op_start  input  1  issue pulse for a mul/div op; sampled only in IDLE
- op_is_div  input  1  1 = divide, 0 = multiply
- op_signed  input  1  1 = signed operation
- op_a  input  W  raw dividend / multiplicand, used for sign and div-by-zero result
- op_b  input  W  raw divisor / multiplier, used for sign and zero detect
- res_valid  input  1  datapath result valid
- res_in  input  2W  for divide, [2W-1:W] = quotient magnitude and [W-1:0] = remainder magnitude; for multiply, the product magnitude
- res_ready  output  1  high only in WAIT
- busy  output  1  high in any state except IDLE
- mf_req  input  1  read request (mfhi/mflo)
- mf_sel  input  1  0 = LO, 1 = HI; shared by mf and mt
- mf_data  output  W  selected register, combinational
- mf_stall  output  1  (mf_req | mt_we) & busy
- mt_we  input  1  write request (mthi/mtlo)
- mt_data  input  W  write data
- dz_flag  output  1  sticky divide-by-zero indicator

Behaviour:
- Reset (async, rst_n=0):
  - state = IDLE; HI = 0; LO = 0; dz_flag = 0.
  - All latched op fields cleared.
  - res_ready = 0, busy = 0, mf_stall = 0.
- FSM states: IDLE, WAIT, FIXUP, COMMIT.
- IDLE:
  - op_start=1: latch op_is_div and op_signed, plus the following, then go to WAIT:
    - neg_q = op_signed & (op_a[W-1] ^ op_b[W-1])
    - neg_r = op_signed & op_a[W-1]
    - a_save = op_a
    - dz = op_is_div & (op_b == 0)
  - op_start also clears dz_flag.
  - mt_we=1 (no op_start) writes mt_data to HI (mf_sel=1) or LO (mf_sel=0) at the clock edge.
  - op_start and mt_we in the same cycle: op_start wins, mt is dropped.
- WAIT:
  - res_ready = 1.
  - On res_valid & res_ready, capture res_in into a 2W holding register and go to FIXUP.
  - res_valid outside WAIT is ignored; res_in is not captured.
- FIXUP (one cycle), applies to the holding register:
  - Divide: quotient field negated (two's complement, W bits) if neg_q; remainder field negated if neg_r.
  - Multiply: full 2W value negated if neg_q.
  - Divide with dz=1: result forced to HI = a_save, LO = all ones; dz_flag set to 1.
  - Then go to COMMIT.
- COMMIT (one cycle):
  - Divide: LO <= quotient, HI <= remainder.
  - Multiply: HI <= [2W-1:W], LO <= [W-1:0].
  - Then go to IDLE.
- Latency: handshake at edge E0; HI/LO visible after edge E2 (E0 -> FIXUP, E1 -> COMMIT, E2 -> IDLE with HI/LO written). busy drops after E2.
- op_start while busy: ignored, no queueing.
- mf_data = mf_sel ? HI : LO at all times. It is valid for the consumer only when mf_req & !mf_stall.
- mt_we while busy: stalls via mf_stall and is not written. The requester holds the request until the stall clears.
- Negation of the most-negative value wraps to itself (e.g. 0x8000_0000 stays 0x8000_0000); no overflow flag.
- dz_flag holds until the next op_start or reset.
- Reset mid-operation returns to IDLE immediately. The pending result is discarded; HI/LO = 0.

Test Plan:
- Unsigned div:
  - op_start, op_is_div=1, op_signed=0, a=7, b=2.
  - res_in = {32'd3, 32'd1}, res_valid=1.
  - Expect res_ready=1 in WAIT; after 3 edges LO=3, HI=1, busy=0.
- Signed div:
  - a = 0xFFFF_FFF9 (-7), b=2, res_in = {3, 1}.
  - Expect LO = 0xFFFF_FFFD, HI = 0xFFFF_FFFF.
  - Repeat with a=7, b=-2: LO = 0xFFFF_FFFD, HI = 1.
- Signed mul:
  - a = -3, b = 5, res_in = 64'd15.
  - Expect HI = 0xFFFF_FFFF, LO = 0xFFFF_FFF1.
- Divide by zero:
  - a = 0x1234_5678, b = 0, res_in = arbitrary.
  - Expect LO = 0xFFFF_FFFF, HI = 0x1234_5678, dz_flag=1.
  - Next op_start clears dz_flag.
- Interlock:
  - mf_req=1 and mt_we=1 during WAIT/FIXUP/COMMIT: mf_stall=1, HI/LO unchanged by mt.
  - In IDLE, mt_we with mf_sel=1, mt_data = 0xAAAA_5555: next cycle mf_data (mf_sel=1) = 0xAAAA_5555.
  - A second op_start while busy does not change state.
- Reset mid-op:
  - rst_n low during FIXUP: state=IDLE, HI=LO=0, res_ready=0 immediately (async).
  - After release, a normal op completes correctly.

Source files
------------

// File: rtl/hilo_writeback.sv
// HI/LO architectural register writeback for the mul/div unit: takes the unsigned
// magnitude result, applies signed fix-up, commits HI/LO and serves mfhi/mflo/mthi/mtlo.
module hilo_writeback #(
  parameter int unsigned W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           op_start,
  input  logic           op_is_div,
  input  logic           op_signed,
  input  logic [W-1:0]   op_a,
  input  logic [W-1:0]   op_b,
  input  logic           res_valid,
  input  logic [2*W-1:0] res_in,
  output logic           res_ready,
  output logic           busy,
  input  logic           mf_req,
  input  logic           mf_sel,
  output logic [W-1:0]   mf_data,
  output logic           mf_stall,
  input  logic           mt_we,
  input  logic [W-1:0]   mt_data,
  output logic           dz_flag
);

  localparam int unsigned W2 = 2 * W;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_FIXUP  = 2'd2,
    S_COMMIT = 2'd3
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [W-1:0]   r_hi;
  logic [W-1:0]   r_lo;
  logic [W-1:0]   r_a_save;
  logic [W2-1:0]  r_res;
  logic [W2-1:0]  w_fix;
  logic [W-1:0]   w_q;
  logic [W-1:0]   w_r;
  logic           r_is_div;
  logic           r_neg_q;
  logic           r_neg_r;
  logic           r_dz;
  logic           r_dz_flag;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; op_start is only honoured in IDLE, res_valid only in WAIT
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (op_start)  w_next = S_WAIT;
      S_WAIT:   if (res_valid) w_next = S_FIXUP;
      S_FIXUP:  w_next = S_COMMIT;
      S_COMMIT: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  assign w_q = r_res[W2-1:W];
  assign w_r = r_res[W-1:0];

  // Signed fix-up of the held magnitude; negating the most-negative value wraps
  always_comb begin
    w_fix = r_res;
    if (r_is_div) begin
      if (r_dz) w_fix = {{W{1'b1}}, r_a_save};
      else      w_fix = {(r_neg_q ? W'(-w_q) : w_q), (r_neg_r ? W'(-w_r) : w_r)};
    end else if (r_neg_q) begin
      w_fix = W2'(-r_res);
    end
  end

  // Op latch, result holding register and architectural HI/LO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi      <= '0;
      r_lo      <= '0;
      r_a_save  <= '0;
      r_res     <= '0;
      r_is_div  <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_dz      <= 1'b0;
      r_dz_flag <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (op_start) begin
            r_is_div  <= op_is_div;
            r_neg_q   <= op_signed & (op_a[W-1] ^ op_b[W-1]);
            r_neg_r   <= op_signed & op_a[W-1];
            r_a_save  <= op_a;
            r_dz      <= op_is_div & (op_b == '0);
            r_dz_flag <= 1'b0;
          end else if (mt_we) begin
            if (mf_sel) r_hi <= mt_data;
            else        r_lo <= mt_data;
          end
        end
        S_WAIT: begin
          if (res_valid) r_res <= res_in;
        end
        S_FIXUP: begin
          r_res <= w_fix;
          if (r_is_div && r_dz) r_dz_flag <= 1'b1;
        end
        S_COMMIT: begin
          // Divide holds {quotient, remainder}: quotient goes to LO
          if (r_is_div) begin
            r_lo <= r_res[W2-1:W];
            r_hi <= r_res[W-1:0];
          end else begin
            r_hi <= r_res[W2-1:W];
            r_lo <= r_res[W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign res_ready = (r_state == S_WAIT);
  assign busy      = (r_state != S_IDLE);
  assign mf_stall  = (mf_req | mt_we) & busy;
  assign mf_data   = mf_sel ? r_hi : r_lo;
  assign dz_flag   = r_dz_flag;

endmodule

// File: tb/tb_hilo_writeback.sv
// Directed bench for hilo_writeback: stimulus queues expected register reads,
// a monitor pops and compares whenever an unstalled mf read is presented.
module tb_hilo_writeback;

  localparam int unsigned W = 32;

  logic           clk;
  logic           rst_n;
  logic           op_start;
  logic           op_is_div;
  logic           op_signed;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic           res_valid;
  logic [2*W-1:0] res_in;
  logic           res_ready;
  logic           busy;
  logic           mf_req;
  logic           mf_sel;
  logic [W-1:0]   mf_data;
  logic           mf_stall;
  logic           mt_we;
  logic [W-1:0]   mt_data;
  logic           dz_flag;

  int n_vec;
  int n_err;
  logic [W-1:0] exp_q[$];

  hilo_writeback #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .op_start(op_start), .op_is_div(op_is_div), .op_signed(op_signed),
    .op_a(op_a), .op_b(op_b),
    .res_valid(res_valid), .res_in(res_in), .res_ready(res_ready), .busy(busy),
    .mf_req(mf_req), .mf_sel(mf_sel), .mf_data(mf_data), .mf_stall(mf_stall),
    .mt_we(mt_we), .mt_data(mt_data), .dz_flag(dz_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every unstalled read presented to the consumer is scored
  always @(negedge clk) begin
    if (rst_n && mf_req && !mf_stall) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL mf_read: unexpected read got %h expected none", mf_data);
      end else begin
        check("mf_read", 64'(mf_data), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_reg(input logic sel, input logic [W-1:0] exp);
    mf_req = 1'b1;
    mf_sel = sel;
    exp_q.push_back(exp);
    step();
    mf_req = 1'b0;
  endtask

  // Full op: issue, handshake, then read back LO and HI after the commit
  task automatic run_op(input string nm, input logic is_div, input logic sgn,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] res,
                        input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                        input logic exp_dz);
    op_start = 1'b1; op_is_div = is_div; op_signed = sgn; op_a = a; op_b = b;
    step();
    op_start = 1'b0;
    check({nm, "_ready_wait"}, 64'(res_ready), 64'd1);
    check({nm, "_dz_clear"}, 64'(dz_flag), 64'd0);
    res_valid = 1'b1; res_in = res;
    step();
    res_valid = 1'b0; res_in = '0;
    check({nm, "_ready_fixup"}, 64'(res_ready), 64'd0);
    step();
    check({nm, "_busy_commit"}, 64'(busy), 64'd1);
    step();
    check({nm, "_busy_done"}, 64'(busy), 64'd0);
    check({nm, "_dz_flag"}, 64'(dz_flag), 64'(exp_dz));
    read_reg(1'b0, exp_lo);
    read_reg(1'b1, exp_hi);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; op_start = 1'b0; op_is_div = 1'b0; op_signed = 1'b0;
    op_a = '0; op_b = '0; res_valid = 1'b0; res_in = '0;
    mf_req = 1'b0; mf_sel = 1'b0; mt_we = 1'b0; mt_data = '0;
    step(); step();
    mf_req = 1'b1;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ready", 64'(res_ready), 64'd0);
    check("rst_stall", 64'(mf_stall), 64'd0);
    check("rst_dz", 64'(dz_flag), 64'd0);
    check("rst_lo", 64'(mf_data), 64'd0);
    mf_sel = 1'b1;
    #1;
    check("rst_hi", 64'(mf_data), 64'd0);
    mf_req = 1'b0; mf_sel = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    // res_valid outside WAIT is ignored
    res_valid = 1'b1; res_in = 64'hDEAD_BEEF_DEAD_BEEF;
    step();
    res_valid = 1'b0;
    check("idle_resvalid_busy", 64'(busy), 64'd0);
    read_reg(1'b0, 32'h0);

    run_op("udiv",     1'b1, 1'b0, 32'd7,         32'd2,         {32'd3, 32'd1},
           32'd1,         32'd3,         1'b0);
    run_op("sdiv_nn",  1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2,         {32'd3, 32'd1},
           32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("sdiv_pn",  1'b1, 1'b1, 32'd7,         32'hFFFF_FFFE, {32'd3, 32'd1},
           32'd1,         32'hFFFF_FFFD, 1'b0);
    run_op("smul_np",  1'b0, 1'b1, 32'hFFFF_FFFD, 32'd5,         64'd15,
           32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    run_op("smul_nn",  1'b0, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 64'd15,
           32'd0,         32'd15,        1'b0);
    run_op("sdiv_min", 1'b1, 1'b1, 32'h8000_0000, 32'd1,         {32'h8000_0000, 32'd0},
           32'd0,         32'h8000_0000, 1'b0);
    run_op("udiv_dz",  1'b1, 1'b0, 32'h1234_5678, 32'd0,         64'h0BAD_F00D_CAFE_1234,
           32'h1234_5678, 32'hFFFF_FFFF, 1'b1);
    run_op("umul_clr", 1'b0, 1'b0, 32'd6,         32'd7,         64'd42,
           32'd0,         32'd42,        1'b0);
    run_op("sdiv_dz",  1'b1, 1'b1, 32'hFFFF_FFF9, 32'd0,         64'd0,
           32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);

    // mthi / mtlo in IDLE
    mt_we = 1'b1; mf_sel = 1'b1; mt_data = 32'hAAAA_5555;
    step();
    mt_we = 1'b0;
    read_reg(1'b1, 32'hAAAA_5555);
    mt_we = 1'b1; mf_sel = 1'b0; mt_data = 32'h0F0F_1234;
    step();
    mt_we = 1'b0;
    read_reg(1'b0, 32'h0F0F_1234);

    // op_start and mt_we together: op wins, mt dropped
    op_start = 1'b1; op_is_div = 1'b1; op_signed = 1'b0; op_a = 32'd100; op_b = 32'd7;
    mt_we = 1'b1; mf_sel = 1'b0; mt_data = 32'h5555_AAAA;
    step();
    op_start = 1'b0; mt_we = 1'b0;
    check("start_mt_busy", 64'(busy), 64'd1);
    // Interlock: mf/mt and a second op_start while busy
    mf_req = 1'b1; mt_we = 1'b1; mf_sel = 1'b1; mt_data = 32'hDEAD_BEEF;
    op_start = 1'b1; op_is_div = 1'b0; op_signed = 1'b1; op_a = 32'hFFFF_FFFF; op_b = 32'd3;
    #1;
    check("stall_wait", 64'(mf_stall), 64'd1);
    step();
    check("restart_ignored", 64'(res_ready), 64'd1);
    op_start = 1'b0;
    res_valid = 1'b1; res_in = {32'd14, 32'd2};
    step();
    res_valid = 1'b0;
    check("stall_fixup", 64'(mf_stall), 64'd1);
    op_start = 1'b1;
    step();
    check("stall_commit", 64'(mf_stall), 64'd1);
    step();
    op_start = 1'b0; mf_req = 1'b0; mt_we = 1'b0;
    check("interlock_done", 64'(busy), 64'd0);
    read_reg(1'b0, 32'd14);
    read_reg(1'b1, 32'd2);

    // Reset during FIXUP
    op_start = 1'b1; op_is_div = 1'b1; op_signed = 1'b1; op_a = 32'hFFFF_FFF9; op_b = 32'd2;
    step();
    op_start = 1'b0;
    res_valid = 1'b1; res_in = {32'd3, 32'd1};
    step();
    res_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_ready", 64'(res_ready), 64'd0);
    mf_sel = 1'b0;
    #1;
    check("midrst_lo", 64'(mf_data), 64'd0);
    mf_sel = 1'b1;
    #1;
    check("midrst_hi", 64'(mf_data), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    run_op("post_rst", 1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE, {32'd3, 32'd1},
           32'd1, 32'hFFFF_FFFD, 1'b0);

    step(); step();
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d reads outstanding, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
